mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit serving the EX stage of the 5-stage pipelined MIPS core.
- Executes mult/multu/div/divu and owns the architectural HI/LO registers.
- Accepts mthi/mtlo writes.
- Exposes busy so the hazard unit stalls mfhi/mflo and any further MD instruction in ID.
- Operands arrive already forwarded from EX. HI/LO feed the EX ALU B-source mux.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (>=1).
- DIV_ITER, 32, restoring-division iterations, equal to the operand width; fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- src_a  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- src_b  in  32  rt operand (divisor / multiplier).
- start  in  1  launch md_op this cycle.
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- hilo_write  in  1  mthi/mtlo write strobe.
- hilo_sel  in  1  1 = HI, 0 = LO target of hilo_write.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (rst low, async): state IDLE, busy=0, hi=0, lo=0, counters and datapath regs cleared. Reset mid-operation aborts it with no HI/LO update.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, start=1 at edge T0:
  - Latch the operands and the op.
  - mult/multu → MUL with counter = MUL_LAT-1.
  - div/divu → DIV with counter = 31.
- MUL:
  - Full 64-bit product, signed or unsigned, is computed from the latched operands.
  - Counter decrements each cycle; at 0, write hi=prod[63:32], lo=prod[31:0] and go to IDLE.
  - busy is high on cycles T0+1 .. T0+MUL_LAT.
- DIV:
  - Signed ops latch |src_a| and |src_b| as unsigned, plus the quotient and remainder signs (qneg = sa^sb, rneg = sa).
  - One restoring step per cycle over a 33-bit partial remainder, 32 steps, then FIX.
- FIX:
  - Negate the quotient if qneg, negate the remainder if rneg.
  - Write lo=quotient, hi=remainder, go to IDLE.
  - busy is high on cycles T0+1 .. T0+33.
- busy is combinational on state (state != IDLE). HI/LO change only at the final edge and are stable otherwise.
- Divide by zero: lo=32'hFFFFFFFF, hi=src_a as latched (raw, unsigned view). Same 33-cycle latency, no exception.
- Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0. This is the natural result of the magnitude datapath.
- start while busy: ignored (the hazard unit guarantees it never happens). The op is not queued.
- hilo_write in IDLE: hi or lo <= src_a at the edge, visible the next cycle. hilo_write while busy: ignored.
- start and hilo_write in the same cycle: start wins and hilo_write is dropped.
- Back-to-back ops: start is accepted in the cycle busy falls (IDLE). The new op reads operands already forwarded; the unit does no internal forwarding.
- No output is X after reset. Signed/unsigned is decided solely by md_op[0] (0 = signed).

Decomposition:
- Shared package mips_md_pkg:
  - md_op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encoding.
  - Constants DIV_STEPS=32 and DIV_LAT=33.
- Sub-module div_core: iterative unsigned restoring divider.
  - Ports: load, dividend, divisor, step.
  - Outputs: quotient, remainder, done.
- mult_div_unit keeps the FSM, sign handling, multiplier and HI/LO.

Test Plan:
- Reset and mthi/mtlo: rst low then high; hilo_write sel=1 src_a=0x12345678, then sel=0 src_a=0x9ABCDEF0 → next cycle hi=0x12345678, lo=0x9ABCDEF0, busy never asserted.
- mult: -3 × 7 (0xFFFFFFFD, 0x00000007) → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu: 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed div: -7 / 2 → busy high exactly 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu and divide-by-zero:
  - divu 100 / 7 → lo=0x0000000E, hi=0x00000002.
  - divu 5 / 0 → lo=0xFFFFFFFF, hi=0x00000005.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Interference and abort:
  - During a div, pulse start (multu 2×3) and hilo_write → both ignored and the div result is unchanged.
  - Assert rst low at cycle 10 of a div → busy=0, hi=lo=0 immediately; after release, a fresh mult 4×5 gives lo=20, hi=0.

Source files
------------

// File: rtl/mips_md_pkg.sv
// Shared encodings and constants for the multiply/divide unit and its divider core.
package mips_md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int DIV_STEPS = 32;
   localparam int DIV_LAT   = 33;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdState_t;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider, one quotient bit per step; DIV_STEPS steps after load.
// No backpressure: the owner pulses step once per cycle and samples when done is high.
module div_core
   import mips_md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        step,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic [5:0]  cnt;
   logic [32:0] shifted;

   // 33-bit partial remainder: the running remainder with the next dividend bit shifted in.
   assign shifted = {rem, quo[31]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (load) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
         cnt <= 6'(DIV_STEPS);
      end else if (step && cnt != 6'd0) begin
         cnt <= cnt - 6'd1;
         if (shifted >= {1'b0, dvs}) begin
            rem <= shifted[31:0] - dvs;
            quo <= {quo[30:0], 1'b1};
         end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
         end
      end
   end

   assign quotient  = quo;
   assign remainder = rem;
   assign done      = (cnt == 6'd0);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu owning HI/LO: MUL_LAT busy cycles for multiply, 33 for divide.
// No backpressure: start/hilo_write while busy are dropped; the hazard unit stalls on busy.
module mult_div_unit
   import mips_md_pkg::*;
#(
   parameter int MUL_LAT  = 5,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic        hilo_write,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdState_t    state;
   logic [7:0]  cnt;
   logic [31:0] aLat;
   logic [31:0] bLat;
   logic        isSigned;
   logic        qNeg;
   logic        rNeg;
   logic        divZero;
   logic [31:0] hiReg;
   logic [31:0] loReg;

   logic        opSigned;
   logic        sa;
   logic        sb;
   logic [31:0] absA;
   logic [31:0] absB;
   logic [63:0] aExt;
   logic [63:0] bExt;
   logic [63:0] prod;
   logic        divLoad;
   logic        divStep;
   logic        divDone;
   logic [31:0] quo;
   logic [31:0] rem;

   assign opSigned = ~md_op[0];
   assign sa       = opSigned & src_a[31];
   assign sb       = opSigned & src_b[31];
   assign absA     = sa ? (32'd0 - src_a) : src_a;
   assign absB     = sb ? (32'd0 - src_b) : src_b;

   // Sign- or zero-extending to 64 bits lets one modular multiply serve both signednesses.
   assign aExt = {{32{isSigned & aLat[31]}}, aLat};
   assign bExt = {{32{isSigned & bLat[31]}}, bLat};
   assign prod = aExt * bExt;

   assign divLoad = (state == ST_IDLE) && start && md_op[1];
   assign divStep = (state == ST_DIV);

   div_core u_divCore (
      .clk       (clk),
      .rst       (rst),
      .load      (divLoad),
      .dividend  (absA),
      .divisor   (absB),
      .step      (divStep),
      .quotient  (quo),
      .remainder (rem),
      .done      (divDone)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         aLat     <= '0;
         bLat     <= '0;
         isSigned <= 1'b0;
         qNeg     <= 1'b0;
         rNeg     <= 1'b0;
         divZero  <= 1'b0;
         hiReg    <= '0;
         loReg    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  aLat     <= src_a;
                  bLat     <= src_b;
                  isSigned <= opSigned;
                  qNeg     <= sa ^ sb;
                  rNeg     <= sa;
                  divZero  <= (src_b == 32'd0);
                  if (md_op[1]) begin
                     state <= ST_DIV;
                     cnt   <= 8'(DIV_ITER - 1);
                  end else begin
                     state <= ST_MUL;
                     cnt   <= 8'(MUL_LAT - 1);
                  end
               end else if (hilo_write) begin
                  if (hilo_sel) hiReg <= src_a;
                  else          loReg <= src_a;
               end
            end
            ST_MUL: begin
               if (cnt == 8'd0) begin
                  hiReg <= prod[63:32];
                  loReg <= prod[31:0];
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_DIV: begin
               if (cnt == 8'd0) state <= ST_FIX;
               else             cnt   <= cnt - 8'd1;
            end
            ST_FIX: begin
               if (divDone) begin
                  // Divide by zero reports the raw dividend, so the sign fix-up is bypassed.
                  if (divZero) begin
                     loReg <= 32'hFFFF_FFFF;
                     hiReg <= aLat;
                  end else begin
                     loReg <= qNeg ? (32'd0 - quo) : quo;
                     hiReg <= rNeg ? (32'd0 - rem) : rem;
                  end
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign hi   = hiReg;
   assign lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every cycle plus literal results.
module tb_mult_div_unit;

   localparam int MUL_LAT = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        start = 1'b0;
   logic [1:0]  md_op = '0;
   logic        hilo_write = 1'b0;
   logic        hilo_sel = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int nCmp = 0;
   int nErr = 0;
   bit chkEn = 1'b0;

   mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_a      (src_a),
      .src_b      (src_b),
      .start      (start),
      .md_op      (md_op),
      .hilo_write (hilo_write),
      .hilo_sel   (hilo_sel),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the instruction definitions.
   function automatic void mdModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
      longint sp;
      longint unsigned up;
      int sa;
      int sb;
      sa = a;
      sb = b;
      h = '0;
      l = '0;
      case (op)
         2'b00: begin
            sp = longint'(sa) * longint'(sb);
            h = sp[63:32];
            l = sp[31:0];
         end
         2'b01: begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            h = up[63:32];
            l = up[31:0];
         end
         2'b10: begin
            if (b == 32'd0) begin
               l = 32'hFFFF_FFFF; h = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               l = 32'h8000_0000; h = 32'd0;
            end else begin
               l = sa / sb; h = sa % sb;
            end
         end
         default: begin
            if (b == 32'd0) begin
               l = 32'hFFFF_FFFF; h = a;
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   int          mBusyLeft = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic [31:0] pHi = '0;
   logic [31:0] pLo = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mBusyLeft = 0;
         mHi = '0;
         mLo = '0;
      end else if (mBusyLeft > 0) begin
         mBusyLeft--;
         if (mBusyLeft == 0) begin
            mHi = pHi;
            mLo = pLo;
         end
      end else if (start) begin
         mdModel(md_op, src_a, src_b, pHi, pLo);
         mBusyLeft = md_op[1] ? 33 : MUL_LAT;
      end else if (hilo_write) begin
         if (hilo_sel) mHi = src_a;
         else          mLo = src_a;
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         check("busy_model", {31'd0, busy}, {31'd0, (mBusyLeft > 0)});
         check("hi_model", hi, mHi);
         check("lo_model", lo, mLo);
      end
   end

   task automatic runOp(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc,
                        input bit disturb, input bit hw);
      int cyc;
      @(posedge clk); #1;
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      hilo_write = hw; hilo_sel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hilo_write = 1'b0; src_a = '0; src_b = '0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         if (disturb && cyc == 3) begin
            start = 1'b1; md_op = 2'b01; src_a = 32'd2; src_b = 32'd3;
            hilo_write = 1'b1; hilo_sel = 1'b1;
         end else begin
            start = 1'b0; hilo_write = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; hilo_write = 1'b0;
      check({nm, "_cycles"}, 32'(cyc), 32'(eCyc));
      check({nm, "_hi"}, hi, eHi);
      check({nm, "_lo"}, lo, eLo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      rst = 1'b1;
      chkEn = 1'b1;

      @(posedge clk); #1;
      hilo_write = 1'b1; hilo_sel = 1'b1; src_a = 32'h1234_5678;
      @(posedge clk); #1;
      hilo_sel = 1'b0; src_a = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      hilo_write = 1'b0; src_a = '0;
      check("mthi_hi", hi, 32'h1234_5678);
      check("mtlo_lo", lo, 32'h9ABC_DEF0);
      check("mthi_busy", {31'd0, busy}, 32'd0);

      runOp("mult", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, 1'b0, 1'b0);
      runOp("multu_hw", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 1'b0, 1'b1);
      runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);
      runOp("divu_disturb", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33, 1'b1, 1'b0);
      runOp("divu_zero", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
      runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0, 1'b0);
      runOp("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
      runOp("div_pos_neg", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);

      @(posedge clk); #1;
      start = 1'b1; md_op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      runOp("mult_after_abort", 2'b00, 32'd4, 32'd5, 32'd0, 32'd20, MUL_LAT, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
